// File: rtl/cpu_board_ctrl.sv
// Board front end for the 4-bit CPU: button conditioning, step/run clock-enable
// generation and a hex 7-segment display with leading-zero blanking.
//
// state   | meaning
// ST_STEP | single-step: each debounced step press issues one cpu_ce pulse
// ST_RUN  | free-run: prescaler wrap issues cpu_ce, step presses ignored
module cpu_board_ctrl #(
   parameter int DATA_W       = 8,
   parameter int NUM_DIGITS   = 6,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int RUN_DIV      = 25000000
) (
   input  logic                    clk1,
   input  logic                    rst_n,
   input  logic                    btn_step,
   input  logic                    btn_mode,
   input  logic [DATA_W-1:0]       value,
   input  logic                    blank_lz,
   output logic                    cpu_ce,
   output logic                    run_mode,
   output logic [15:0]             step_cnt,
   output logic [8*NUM_DIGITS-1:0] hex
);

   localparam int ND   = (DATA_W + 3) / 4;
   localparam int DB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int PS_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
   localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [PS_W-1:0] PS_TC = PS_W'(RUN_DIV - 1);

   typedef enum logic {ST_STEP = 1'b0, ST_RUN = 1'b1} state_t;

   // index 0 = step button, index 1 = mode button
   logic [1:0]      btn_raw;
   logic [1:0]      sync1, sync2, db, db_d, press;
   logic [DB_W-1:0] db_cnt [2];

   state_t          state, state_nxt;
   logic [PS_W-1:0] presc, presc_nxt;
   logic            cpu_ce_nxt;

   logic [DATA_W-1:0]       val_q;
   logic [4*ND-1:0]         val_ext;
   logic [8*NUM_DIGITS-1:0] hex_nxt;
   logic [3:0]              nib;
   logic                    nz_above;

   assign btn_raw  = {btn_mode, btn_step};
   assign run_mode = (state == ST_RUN);

   // press is taken from the registered debounced edge so the pulse is glitch-free
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= '1;
         sync2     <= '1;
         db        <= '1;
         db_d      <= '1;
         press     <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         db_d  <= db;
         press <= db_d & ~db;
         for (int b = 0; b < 2; b++) begin
            if (sync2[b] == db[b]) begin
               db_cnt[b] <= '0;
            end else if (db_cnt[b] == DB_TC) begin
               db[b]     <= sync2[b];
               db_cnt[b] <= '0;
            end else begin
               db_cnt[b] <= db_cnt[b] + DB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_STEP;
         presc    <= '0;
         cpu_ce   <= 1'b0;
         step_cnt <= '0;
      end else begin
         state    <= state_nxt;
         presc    <= presc_nxt;
         cpu_ce   <= cpu_ce_nxt;
         step_cnt <= step_cnt + 16'(cpu_ce);
      end
   end

   // a mode press wins over a coincident step press or prescaler wrap
   always_comb begin
      state_nxt  = state;
      presc_nxt  = presc;
      cpu_ce_nxt = 1'b0;
      if (press[1]) begin
         state_nxt = (state == ST_STEP) ? ST_RUN : ST_STEP;
         presc_nxt = '0;
      end else begin
         case (state)
            ST_STEP: cpu_ce_nxt = press[0];
            ST_RUN: begin
               if (presc == PS_TC) begin
                  presc_nxt  = '0;
                  cpu_ce_nxt = 1'b1;
               end else begin
                  presc_nxt = presc + PS_W'(1);
               end
            end
            default: state_nxt = ST_STEP;
         endcase
      end
   end

   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 8'hC0;
         4'h1: seg7 = 8'hF9;
         4'h2: seg7 = 8'hA4;
         4'h3: seg7 = 8'hB0;
         4'h4: seg7 = 8'h99;
         4'h5: seg7 = 8'h92;
         4'h6: seg7 = 8'h82;
         4'h7: seg7 = 8'hF8;
         4'h8: seg7 = 8'h80;
         4'h9: seg7 = 8'h90;
         4'hA: seg7 = 8'h88;
         4'hB: seg7 = 8'h83;
         4'hC: seg7 = 8'hC6;
         4'hD: seg7 = 8'hA1;
         4'hE: seg7 = 8'h86;
         default: seg7 = 8'h8E;
      endcase
   endfunction

   always_comb begin
      val_ext               = '0;
      val_ext[DATA_W-1:0]   = val_q;
      hex_nxt               = '1;
      nib                   = '0;
      nz_above              = 1'b0;
      // scan from the MSB nibble so blanking stops at the first nonzero digit
      for (int i = ND - 1; i >= 0; i--) begin
         nib      = val_ext[4*i +: 4];
         nz_above = nz_above | (nib != 4'h0);
         if (!blank_lz || nz_above || (i == 0))
            hex_nxt[8*i +: 8] = seg7(nib);
      end
      hex_nxt[7] = ~run_mode;
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         val_q <= '0;
         hex   <= '1;
      end else begin
         val_q <= value;
         hex   <= hex_nxt;
      end
   end

endmodule

// File: tb/tb_cpu_board_ctrl.sv
// Directed bench for cpu_board_ctrl: expected cpu_ce pulses are queued with their
// cycle and step count; a monitor pops and compares them as the DUT emits pulses.
module tb_cpu_board_ctrl;

   logic        clk1;
   logic        rst_n;
   logic        btn_step;
   logic        btn_mode;
   logic [7:0]  value;
   logic        blank_lz;
   logic        cpu_ce;
   logic        run_mode;
   logic [15:0] step_cnt;
   logic [47:0] hex;

   int cyc     = 0;
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          cyc;
      logic [15:0] cnt;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [7:0]  v;
      logic        b;
      logic [47:0] h;
   } disp_t;
   disp_t disp_tab[$];

   cpu_board_ctrl #(
      .DATA_W      (8),
      .NUM_DIGITS  (6),
      .DEBOUNCE_CYC(4),
      .RUN_DIV     (5)
   ) dut (
      .clk1    (clk1),
      .rst_n   (rst_n),
      .btn_step(btn_step),
      .btn_mode(btn_mode),
      .value   (value),
      .blank_lz(blank_lz),
      .cpu_ce  (cpu_ce),
      .run_mode(run_mode),
      .step_cnt(step_cnt),
      .hex     (hex)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   always @(posedge clk1) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_pulse(input int c, input logic [15:0] cnt);
      exp_t e;
      e.cyc = c;
      e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk1);
   endtask

   // monitor: every cpu_ce pulse must match the head of the queue
   always @(negedge clk1) begin
      exp_t e;
      if (cpu_ce) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL cpu_ce_unexpected: pulse at cycle %0d step_cnt %h, none expected",
                     cyc, step_cnt);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.cnt != step_cnt) begin
               n_fail++;
               $display("FAIL cpu_ce_pulse: got cycle %0d step_cnt %h expected cycle %0d step_cnt %h",
                        cyc, step_cnt, e.cyc, e.cnt);
            end
         end
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         n_checks++;
         n_fail++;
         e = exp_q.pop_front();
         $display("FAIL cpu_ce_missing: no pulse by cycle %0d, expected at cycle %0d", cyc, e.cyc);
      end
   end

   initial begin
      int n0;
      rst_n    = 1'b0;
      btn_step = 1'b1;
      btn_mode = 1'b1;
      value    = 8'h3A;
      blank_lz = 1'b0;

      disp_tab.push_back('{8'h00, 1'b0, 48'hFFFF_FFFF_C0C0});
      disp_tab.push_back('{8'h00, 1'b1, 48'hFFFF_FFFF_FFC0});
      disp_tab.push_back('{8'h80, 1'b1, 48'hFFFF_FFFF_80C0});
      disp_tab.push_back('{8'h0F, 1'b1, 48'hFFFF_FFFF_FF8E});
      disp_tab.push_back('{8'h0F, 1'b0, 48'hFFFF_FFFF_C08E});
      disp_tab.push_back('{8'hD7, 1'b0, 48'hFFFF_FFFF_A1F8});
      disp_tab.push_back('{8'h6E, 1'b1, 48'hFFFF_FFFF_8286});
      disp_tab.push_back('{8'h19, 1'b1, 48'hFFFF_FFFF_F990});
      disp_tab.push_back('{8'hB4, 1'b1, 48'hFFFF_FFFF_8399});
      disp_tab.push_back('{8'h2C, 1'b0, 48'hFFFF_FFFF_A4C6});

      wait_cyc(3);
      chk("rst_cpu_ce",   48'(cpu_ce),   48'h0);
      chk("rst_run_mode", 48'(run_mode), 48'h0);
      chk("rst_step_cnt", 48'(step_cnt), 48'h0);
      chk("rst_hex",      hex,           48'hFFFF_FFFF_FFFF);
      rst_n = 1'b1;
      wait_cyc(2);
      chk("hex_3a",       hex,           48'hFFFF_FFFF_B088);
      chk("idle_cpu_ce",  48'(cpu_ce),   48'h0);

      // bounces of 2 and DEBOUNCE_CYC-1 cycles are rejected
      btn_step = 1'b0; wait_cyc(2); btn_step = 1'b1; wait_cyc(12);
      btn_step = 1'b0; wait_cyc(3); btn_step = 1'b1; wait_cyc(12);
      chk("bounce_step_cnt", 48'(step_cnt), 48'h0);

      // held press: one pulse, 7 cycles after the first sampling edge
      push_pulse(cyc + 8, 16'd0);
      btn_step = 1'b0; wait_cyc(10); btn_step = 1'b1; wait_cyc(15);
      chk("step1_cnt", 48'(step_cnt), 48'h1);

      // press exactly DEBOUNCE_CYC cycles long is accepted
      push_pulse(cyc + 8, 16'd1);
      btn_step = 1'b0; wait_cyc(4); btn_step = 1'b1; wait_cyc(15);
      chk("step2_cnt", 48'(step_cnt), 48'h2);

      // free-run: mode press at n0, second mode press at n0+30 stops it
      n0 = cyc;
      for (int c = n0 + 13; c <= n0 + 37; c += 5)
         push_pulse(c, 16'(2 + (c - n0 - 13) / 5));
      btn_mode = 1'b0; wait_cyc(10); btn_mode = 1'b1; wait_cyc(10);
      chk("run_mode_on", 48'(run_mode), 48'h1);
      chk("run_dp",      48'(hex[7]),   48'h0);
      value    = 8'h05;
      blank_lz = 1'b1;
      btn_step = 1'b0;
      wait_cyc(2);
      chk("hex_05_run", hex, 48'hFFFF_FFFF_FF12);
      wait_cyc(6);
      btn_step = 1'b1;
      wait_cyc(2);
      btn_mode = 1'b0; wait_cyc(10); btn_mode = 1'b1; wait_cyc(20);
      chk("run_mode_off", 48'(run_mode), 48'h0);
      chk("run_step_cnt", 48'(step_cnt), 48'h7);
      chk("hex_05_step",  48'(hex[7:0]), 48'h92);

      // simultaneous presses: mode toggles, step discarded; reset mid-prescale
      btn_mode = 1'b0;
      btn_step = 1'b0;
      wait_cyc(9);
      chk("both_run_mode", 48'(run_mode), 48'h1);
      wait_cyc(1);
      btn_mode = 1'b1;
      btn_step = 1'b1;
      wait_cyc(1);
      rst_n    = 1'b0;
      btn_step = 1'b0;
      wait_cyc(1);
      chk("rst2_run_mode", 48'(run_mode), 48'h0);
      chk("rst2_step_cnt", 48'(step_cnt), 48'h0);
      chk("rst2_hex",      hex,           48'hFFFF_FFFF_FFFF);
      wait_cyc(2);
      push_pulse(cyc + 8, 16'd0);
      rst_n = 1'b1;
      wait_cyc(12);
      btn_step = 1'b1;
      wait_cyc(15);
      chk("held_rst_step_cnt", 48'(step_cnt), 48'h1);

      foreach (disp_tab[i]) begin
         value    = disp_tab[i].v;
         blank_lz = disp_tab[i].b;
         wait_cyc(2);
         chk($sformatf("disp_%02h_%0d", disp_tab[i].v, disp_tab[i].b), hex, disp_tab[i].h);
      end

      value    = 8'h3A;
      blank_lz = 1'b0;
      wait_cyc(1);
      chk("hex_latency_old", hex, 48'hFFFF_FFFF_A4C6);
      wait_cyc(1);
      chk("hex_latency_new", hex, 48'hFFFF_FFFF_B088);

      wait_cyc(10);
      chk("pending_pulses", 48'(exp_q.size()), 48'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
